// File: rtl/bcd2bin_seq_if.sv
// bcd2bin_seq handshake bundle: start/bcd_in in, busy/done/err/bin_out/state out.
// master = requester (adder FSM), slave = converter.
interface bcd2bin_seq_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BIN_W-1:0]      bin_out;
  logic [1:0]            state;

  modport master (
    output start, bcd_in,
    input  busy, done, err, bin_out, state
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, err, bin_out, state
  );
endinterface

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift/clk).
// Ports: clk, reset_n (async low), bus (slave: start/bcd_in -> busy/done/err/bin_out/state).
module bcd2bin_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  bcd2bin_seq_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           st;
  logic [BCD_W-1:0] bcd_reg;
  logic [BIN_W-1:0] bin_reg;
  logic [CNT_W-1:0] cnt;
  logic             err_flag;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [BIN_W-1:0] bin_q;

  logic [BCD_W-1:0] bcd_nxt;
  logic [BIN_W-1:0] bin_nxt;
  logic             bad;

  // One reverse-dabble step: shift right, then pull back any nibble
  // that picked up a half-ten (8) from its upper neighbour.
  always_comb begin
    {bcd_nxt, bin_nxt} = {bcd_reg, bin_reg} >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_nxt[4*i +: 4] >= 4'd8)
        bcd_nxt[4*i +: 4] = bcd_nxt[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_reg[4*i +: 4] > 4'd9)
        bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st       <= IDLE;
      bcd_reg  <= '0;
      bin_reg  <= '0;
      cnt      <= '0;
      err_flag <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      bin_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (st)
        IDLE: begin
          if (bus.start) begin
            bcd_reg  <= bus.bcd_in;
            bin_reg  <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
            busy_q   <= 1'b1;
            st       <= CHECK;
          end
        end
        CHECK: begin
          if (bad) begin
            err_flag <= 1'b1;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
            bin_q    <= '0;
            st       <= DONE;
          end else begin
            st <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_nxt;
          bin_reg <= bin_nxt;
          cnt     <= cnt + 1'b1;
          // Outputs load from the final step's value so they
          // are valid in the same cycle done is high.
          if (cnt == LAST) begin
            done_q <= 1'b1;
            err_q  <= err_flag;
            bin_q  <= err_flag ? '0 : bin_nxt;
            st     <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.bin_out = bin_q;
  assign bus.state   = st;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Testbench for bcd2bin_seq: scoreboard of model results checked on done,
// plus latency, busy, hold, ignore-start and async reset checks.
module tb_bcd2bin_seq;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;
  localparam int BCD_W  = 4 * DIGITS;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_miss;
  exp_t sb[$];
  logic [BIN_W-1:0] last_bin;
  logic             last_err;

  bcd2bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain decimal weighting of the digits.
  function automatic exp_t model(input logic [BCD_W-1:0] b);
    exp_t e;
    int   val;
    int   w;
    int   d;
    val   = 0;
    w     = 1;
    e.err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'((b >> (4 * i)) & BCD_W'(15));
      if (d > 9) e.err = 1'b1;
      val = val + d * w;
      w   = w * 10;
    end
    e.bin = e.err ? '0 : BIN_W'(val);
    return e;
  endfunction

  function automatic bit is_err(input logic [BCD_W-1:0] b);
    exp_t e;
    e = model(b);
    return e.err;
  endfunction

  task automatic push(input logic [BCD_W-1:0] b);
    exp_t e;
    e = model(b);
    sb.push_back(e);
    last_bin = e.bin;
    last_err = e.err;
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: got bin %0d err %0d expected no done",
                 bus.bin_out, bus.err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_bin", int'(bus.bin_out), int'(e.bin));
        chk("sb_err", int'(bus.err), int'(e.err));
      end
    end
  end

  // Entry/exit point: #1 after a rising edge with state IDLE.
  task automatic conv(input logic [BCD_W-1:0] b, input bit poke);
    int lat;
    int bcnt;
    bit seen;
    bit e;
    e = is_err(b);
    bus.start  = 1'b1;
    bus.bcd_in = b;
    push(b);
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.bcd_in = BCD_W'($urandom);
    lat  = 0;
    bcnt = bus.busy ? 1 : 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (poke && lat == 3) begin
        bus.start  = 1'b1;
        bus.bcd_in = 8'h11;
      end
      @(posedge clk); #1;
      if (poke && lat == 3) bus.start = 1'b0;
      lat++;
      if (bus.busy) bcnt++;
      if (bus.done) seen = 1'b1;
    end
    chk("done_seen", int'(seen), 1);
    chk("latency", lat, e ? 1 : BIN_W + 1);
    chk("busy_cycles", bcnt, e ? 2 : BIN_W + 2);
    @(posedge clk); #1;
    chk("busy_low", int'(bus.busy), 0);
    chk("state_idle", int'(bus.state), 0);
    chk("bin_hold", int'(bus.bin_out), int'(last_bin));
    chk("err_hold", int'(bus.err), int'(last_err));
  endtask

  function automatic logic [BCD_W-1:0] rand_bcd();
    logic [BCD_W-1:0] b;
    for (int i = 0; i < DIGITS; i++) begin
      if ($urandom_range(0, 5) == 0)
        b[4*i +: 4] = 4'($urandom_range(0, 15));
      else
        b[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return b;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int prev;
    int seen;
    n_vec     = 0;
    n_miss    = 0;
    last_bin  = '0;
    last_err  = 1'b0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.bcd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_bin", int'(bus.bin_out), 0);
    chk("rst_state", int'(bus.state), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    conv(8'h99, 1'b0);
    conv(8'h00, 1'b0);
    conv(8'h47, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("hold_47", int'(bus.bin_out), 47);
    conv(8'h10, 1'b0);
    conv(8'h3A, 1'b0);
    conv(8'h25, 1'b0);
    conv(8'h56, 1'b1);
    repeat (12) @(posedge clk);
    #1;

    // Async reset in the middle of SHIFT; nothing pushed for it.
    bus.start  = 1'b1;
    bus.bcd_in = 8'h88;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_done", int'(bus.done), 0);
    chk("arst_bin", int'(bus.bin_out), 0);
    chk("arst_err", int'(bus.err), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_state", int'(bus.state), 0);
    #3;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    conv(8'h63, 1'b0);

    // start held high: back-to-back conversions.
    bus.start  = 1'b1;
    bus.bcd_in = 8'h12;
    repeat (3) push(8'h12);
    cyc  = 0;
    prev = -1;
    seen = 0;
    while (seen < 3 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) begin
        if (prev < 0) chk("held_first", cyc, BIN_W + 2);
        else chk("held_spacing", cyc - prev, BIN_W + 3);
        prev = cyc;
        seen++;
        if (seen == 3) bus.start = 1'b0;
      end
    end
    chk("held_count", seen, 3);
    @(posedge clk); #1;

    for (int k = 0; k < 25; k++) conv(rand_bcd(), 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
